// File: rtl/ipf_pkg.sv
// Shared constants, FSM encoding and image-border predicate for the IPF host.
// No latency or flow control of its own; used by the host and its memories.
package ipf_pkg;

    localparam int addrWidth      = 14;
    localparam int dataWidth      = 8;
    localparam int IMG_W          = 128;
    localparam int NUM_PIX        = IMG_W * IMG_W;
    localparam int FIRST_IPF_ADDR = 129;
    localparam int MAX_IPF_ADDR   = 16254;

    localparam logic [addrWidth-1:0] LAST_ADDR = addrWidth'(NUM_PIX - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_SERVE,
        ST_DUMP,
        ST_DONE
    } state_t;

    // Everything below the first interior pixel or above the last one is
    // border; in between, only the left and right columns remain.
    function automatic logic is_border(input logic [addrWidth-1:0] a);
        logic out_of_range;
        logic edge_col;
        out_of_range = (int'(a) < FIRST_IPF_ADDR) || (int'(a) > MAX_IPF_ADDR);
        edge_col     = (a[6:0] == 7'd0) || (a[6:0] == 7'd127);
        return out_of_range || edge_col;
    endfunction

endpackage

// File: rtl/ipf_host_mem.sv
// One frame of pixels: single synchronous write port, asynchronous read port.
// Write lands on the clock edge; read data follows raddr in the same cycle.
module ipf_host_mem
    import ipf_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [addrWidth-1:0] waddr,
    input  logic [dataWidth-1:0] wdata,
    input  logic [addrWidth-1:0] raddr,
    output logic [dataWidth-1:0] rdata
);

    logic [dataWidth-1:0] mem_q [NUM_PIX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ipf_host.sv
// IPF host: loads a frame, starts the filter, serves reads, captures writes, dumps result.
// Gray reads are zero-latency; load accepts one pixel/cycle, dump holds data while out_ready=0.
module ipf_host
    import ipf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           cfg_mode,
    input  logic                 load_valid,
    input  logic [dataWidth-1:0] load_data,
    output logic                 load_ready,
    output logic [1:0]           mode,
    output logic                 gray_ready,
    input  logic                 gray_req,
    input  logic [addrWidth-1:0] gray_addr,
    output logic [dataWidth-1:0] gray_data,
    input  logic                 ipf_valid,
    input  logic [addrWidth-1:0] ipf_addr,
    input  logic [dataWidth-1:0] ipf_data,
    input  logic                 finish,
    output logic                 out_valid,
    output logic [dataWidth-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 done,
    output logic                 proto_err
);

    state_t               state_q, state_d;
    logic [addrWidth-1:0] cnt_q, cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic                 err_q, err_d;

    logic                 gray_we;
    logic                 res_we;
    logic [dataWidth-1:0] gray_rdata;
    logic [dataWidth-1:0] res_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;
        gray_we = 1'b0;
        res_we  = 1'b0;

        if (ipf_valid && ((state_q != ST_SERVE) || is_border(ipf_addr))) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    gray_we = 1'b1;
                    cnt_d   = cnt_q + addrWidth'(1);
                    if (cnt_q == '0) begin
                        mode_d = cfg_mode;
                    end
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                state_d = ST_SERVE;
            end
            ST_SERVE: begin
                // A write arriving together with finish still commits.
                res_we = ipf_valid && !is_border(ipf_addr);
                if (finish) begin
                    cnt_d   = '0;
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (out_ready) begin
                    cnt_d = cnt_q + addrWidth'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            mode_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // Writes are gated by reset so an aborted frame leaves no trailing write.
    ipf_host_mem gray_mem (
        .clk   (clk),
        .we    (gray_we && !reset),
        .waddr (cnt_q),
        .wdata (load_data),
        .raddr (gray_addr),
        .rdata (gray_rdata)
    );

    ipf_host_mem res_mem (
        .clk   (clk),
        .we    (res_we && !reset),
        .waddr (ipf_addr),
        .wdata (ipf_data),
        .raddr (cnt_q),
        .rdata (res_rdata)
    );

    assign load_ready = (state_q == ST_LOAD);
    assign gray_ready = (state_q == ST_START);
    assign out_valid  = (state_q == ST_DUMP);
    assign done       = (state_q == ST_DONE);
    assign mode       = mode_q;
    assign proto_err  = err_q;
    assign out_last   = (state_q == ST_DUMP) && (cnt_q == LAST_ADDR);
    assign out_data   = ((state_q == ST_DUMP) && !is_border(cnt_q)) ? res_rdata : '0;
    assign gray_data  = gray_req ? gray_rdata : '0;

endmodule

// File: tb/tb_ipf_host.sv
// Directed bench for ipf_host with a queue scoreboard on the dump stream.
module tb_ipf_host;
    import ipf_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [1:0]           cfg_mode = '0;
    logic                 load_valid = 1'b0;
    logic [dataWidth-1:0] load_data = '0;
    logic                 load_ready;
    logic [1:0]           mode;
    logic                 gray_ready;
    logic                 gray_req = 1'b0;
    logic [addrWidth-1:0] gray_addr = '0;
    logic [dataWidth-1:0] gray_data;
    logic                 ipf_valid = 1'b0;
    logic [addrWidth-1:0] ipf_addr = '0;
    logic [dataWidth-1:0] ipf_data = '0;
    logic                 finish = 1'b0;
    logic                 out_valid;
    logic [dataWidth-1:0] out_data;
    logic                 out_last;
    logic                 out_ready = 1'b0;
    logic                 done;
    logic                 proto_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         idx;
        logic [7:0] dat;
        bit         known;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] wr[int];

    ipf_host dut (
        .clk(clk), .reset(reset), .cfg_mode(cfg_mode),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .mode(mode), .gray_ready(gray_ready),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .ipf_valid(ipf_valid), .ipf_addr(ipf_addr), .ipf_data(ipf_data),
        .finish(finish),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .done(done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic bit tb_border(input int i);
        int r, c;
        r = i / 128;
        c = i % 128;
        return (r == 0) || (r == 127) || (c == 0) || (c == 127);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_proto_err"},  32'(proto_err),  32'd0);
        chk({tag, "_gray_ready"}, 32'(gray_ready), 32'd0);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_mode"},       32'(mode),       32'd0);
    endtask

    task automatic load_frame(input int n, input int kind, input int inject_at,
                              input logic [1:0] first_mode);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = (kind != 0) ? 8'(3 * i) : 8'(i);
            cfg_mode   = (i == 0) ? first_mode : 2'd3;
            ipf_valid  = (i == inject_at);
            ipf_addr   = 14'd131;
            ipf_data   = 8'h77;
            if (i == 0 || i == NUM_PIX - 1) begin
                #1;
                chk("load_ready_in_load", 32'(load_ready), 32'd1);
            end
            tick();
        end
        load_valid = 1'b0;
        ipf_valid  = 1'b0;
        if (n == NUM_PIX) begin
            chk("load_ready_after_last", 32'(load_ready), 32'd0);
            chk("gray_ready_pulse",      32'(gray_ready), 32'd1);
            tick();
            chk("gray_ready_one_cycle",  32'(gray_ready), 32'd0);
            chk("mode_latched",          32'(mode),       32'(first_mode));
        end
    endtask

    task automatic gray_chk(input int addr, input logic [7:0] exp);
        gray_req  = 1'b1;
        gray_addr = 14'(addr);
        #1;
        chk("gray_data", 32'(gray_data), 32'(exp));
        tick();
    endtask

    task automatic wr_pix(input int addr, input logic [7:0] dat, input logic fin);
        ipf_valid = 1'b1;
        ipf_addr  = 14'(addr);
        ipf_data  = dat;
        finish    = fin;
        if (!tb_border(addr)) wr[addr] = dat;
        tick();
        ipf_valid = 1'b0;
        finish    = 1'b0;
    endtask

    task automatic push_dump();
        exp_t e;
        for (int i = 0; i < NUM_PIX; i++) begin
            e.idx = i;
            if (tb_border(i)) begin
                e.dat = 8'h00; e.known = 1'b1;
            end else if (wr.exists(i)) begin
                e.dat = wr[i]; e.known = 1'b1;
            end else begin
                e.dat = 8'h00; e.known = 1'b0;
            end
            sb.push_back(e);
        end
    endtask

    task automatic dump_run(input int stop_n, input bit hold200, output int n);
        int cyc;
        bit held;
        exp_t e;
        n = 0; cyc = 0; held = 1'b0;
        while (n < stop_n && sb.size() > 0) begin
            if (hold200 && n == 200 && !held) begin
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk("hold_data",  32'(out_data),  32'h0C8);
                    chk("hold_valid", 32'(out_valid), 32'd1);
                end
                held = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_ready) begin
                e = sb.pop_front();
                chk("dump_valid", 32'(out_valid), 32'd1);
                if (e.known) chk($sformatf("dump_data[%0d]", e.idx), 32'(out_data), 32'(e.dat));
                chk($sformatf("dump_last[%0d]", e.idx), 32'(out_last),
                    32'(e.idx == NUM_PIX - 1));
                n++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 60000) begin
                chk("dump_timeout", 32'd0, 32'd1);
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        // Frame A: reset state, then abort a partial load.
        tick();
        do_reset();
        chk_reset("rst0");
        load_frame(5000, 0, -1, 2'd1);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        do_reset();
        load_valid = 1'b0;
        chk_reset("rst_load");

        // Frame B: ramp load, serve reads/writes, full dump with backpressure.
        load_frame(NUM_PIX, 0, -1, 2'd1);
        gray_chk(130, 8'd130);
        gray_chk(0, 8'd0);
        gray_chk(16383, 8'd255);
        gray_req = 1'b0;
        #1;
        chk("gray_req_low", 32'(gray_data), 32'd0);
        tick();
        chk("err_before", 32'(proto_err), 32'd0);
        wr_pix(129, 8'hAB, 1'b0);
        wr_pix(16254, 8'h5C, 1'b0);
        wr_pix(131, 8'h33, 1'b0);
        wr_pix(200, 8'hC8, 1'b0);
        chk("err_interior", 32'(proto_err), 32'd0);
        wr_pix(0, 8'hEE, 1'b0);
        chk("err_border", 32'(proto_err), 32'd1);
        wr_pix(127, 8'h99, 1'b0);
        chk("serve_no_valid", 32'(out_valid), 32'd0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("dump_entered", 32'(out_valid), 32'd1);
        push_dump();
        dump_run(NUM_PIX, 1'b1, n);
        chk("dump_count", 32'(n), 32'(NUM_PIX));
        chk("done_set", 32'(done), 32'd1);
        chk("done_no_out_valid", 32'(out_valid), 32'd0);
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("done_terminal", 32'(done), 32'd1);
        chk("done_load_ready", 32'(load_ready), 32'd0);

        // Frame C: new pattern, illegal write during load, write+finish, reset mid-dump.
        do_reset();
        chk_reset("rst_done");
        sb.delete();
        load_frame(NUM_PIX, 1, 50, 2'd2);
        chk("err_ipf_in_load", 32'(proto_err), 32'd1);
        gray_chk(1000, 8'd184);
        gray_chk(5, 8'd15);
        gray_req = 1'b0;
        wr_pix(132, 8'h44, 1'b1);
        chk("dump_after_finish", 32'(out_valid), 32'd1);
        push_dump();
        dump_run(300, 1'b0, n);
        chk("partial_dump_count", 32'(n), 32'd300);
        do_reset();
        chk_reset("rst_dump");
        sb.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
